// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package mod_counter_pkg;
   localparam logic DIR_UP     = 1'b1;
   localparam logic DIR_DN     = 1'b0;
   localparam int   WRAP_CNT_W = 16;

   // Ceiling log2 for tools without $clog2; never returns less than 1 bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(value)) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clr wins.
module sat_event_counter
   import mod_counter_pkg::*;
#(
   parameter int W = WRAP_CNT_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with load, combinational terminal count and wrap pulse.
// Optional wrap event counter output when MODN_WRAP_CNT_EN is defined.
module mod_n_updown_counter
   import mod_counter_pkg::*;
#(
   parameter int MODULUS = 100,
   parameter int WIDTH   = clog2(MODULUS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
`ifdef MODN_WRAP_CNT_EN
   ,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

   generate
      if ((MODULUS < 2) || ((64'd1 << WIDTH) < 64'(MODULUS))) begin : g_bad_param
         $error("mod_n_updown_counter: MODULUS must be >= 2 and fit in WIDTH bits");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic             at_max;
   logic             at_min;
   logic             count_up;
   logic [WIDTH-1:0] load_clamped;

   assign at_max       = (count == MAX_VAL);
   assign at_min       = (count == '0);
   assign count_up     = (up_dn == DIR_UP);
   assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   // tc is exactly "the next enabled edge crosses a boundary", so it doubles as wrap-next.
   assign tc = en & ~load & ((count_up & at_max) | (~count_up & at_min));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= tc;
         if (load) begin
            count <= load_clamped;
         end else if (en) begin
            if (count_up) begin
               count <= at_max ? '0 : count + 1'b1;
            end else begin
               count <= at_min ? MAX_VAL : count - 1'b1;
            end
         end
      end
   end

`ifdef MODN_WRAP_CNT_EN
   sat_event_counter #(
      .W(WRAP_CNT_W)
   ) u_wrap_cnt (
      .clk(clk),
      .clr(rst),
      .inc(tc),
      .cnt(wrap_cnt)
   );
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: vector table, directed corner sequences, random vs. reference model.
module tb_mod_n_updown_counter;
   import mod_counter_pkg::*;

   localparam int M  = 100;
   localparam int W  = 7;
   localparam int M7 = 7;
   localparam int W7 = 3;

   logic         clk;
   logic         rst, en, up_dn, load;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         tc, wrap;

   logic          rst7, en7, up7, load7;
   logic [W7-1:0] lv7, count7;
   logic          tc7, wrap7;
`ifdef MODN_WRAP_CNT_EN
   logic [WRAP_CNT_W-1:0] wrap_cnt7;
`endif

   logic       sclr, sinc;
   logic [2:0] scnt;

   int checks = 0;
   int errors = 0;

   // reference model state and last observed DUT values
   int m_count = 0;
   int m_wrap  = 0;
   int e_tc;
   int a_tc, a_count, a_wrap;

   typedef struct {
      logic r, e, u, l;
      int   lv;
      int   x_count, x_wrap, x_tc;
   } vec_t;
   vec_t vecs[13];

   mod_n_updown_counter #(.MODULUS(M), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
   );

   mod_n_updown_counter #(.MODULUS(M7), .WIDTH(W7)) dut7 (
      .clk(clk), .rst(rst7), .en(en7), .up_dn(up7), .load(load7),
      .load_val(lv7), .count(count7), .tc(tc7), .wrap(wrap7)
`ifdef MODN_WRAP_CNT_EN
      , .wrap_cnt(wrap_cnt7)
`endif
   );

   sat_event_counter #(.W(3)) u_sat (.clk(clk), .clr(sclr), .inc(sinc), .cnt(scnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of the 100-counter: drive at negedge, sample tc before and count/wrap after the edge.
   task automatic cyc(input logic r, e, u, l, input int lv);
      rst = r; en = e; up_dn = u; load = l; load_val = W'(lv);
      #1;
      a_tc = int'(tc);
      e_tc = (e && !l && (u ? (m_count == M - 1) : (m_count == 0))) ? 1 : 0;
      @(posedge clk);
      if (r) begin
         m_count = 0; m_wrap = 0;
      end else if (l) begin
         m_count = ((lv % 128) >= M) ? M - 1 : (lv % 128); m_wrap = 0;
      end else if (e) begin
         m_wrap  = (u ? (m_count == M - 1) : (m_count == 0)) ? 1 : 0;
         m_count = u ? (m_count + 1) % M : (m_count + M - 1) % M;
      end else begin
         m_wrap = 0;
      end
      #1;
      a_count = int'(count);
      a_wrap  = int'(wrap);
      @(negedge clk);
   endtask

   task automatic chk_model(input string name);
      chk({name, ".tc"},    a_tc,    e_tc);
      chk({name, ".count"}, a_count, m_count);
      chk({name, ".wrap"},  a_wrap,  m_wrap);
   endtask

   task automatic cyc7(input logic r, e);
      rst7 = r; en7 = e; up7 = DIR_UP; load7 = 1'b0; lv7 = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
   endtask

   initial begin
      int wraps7, exp7;
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0,    0, 0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 250, 99, 0, 0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0,    0, 1, 1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   99, 1, 1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0,   99, 0, 0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   98, 0, 0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 42,  42, 0, 0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 100, 99, 0, 0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 99,  99, 0, 0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10,   0, 0, 0};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 0,    1, 0, 0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,    0, 0, 0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   99, 1, 1};

      rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
      rst7 = 1'b1; en7 = 1'b0; up7 = 1'b1; load7 = 1'b0; lv7 = '0;
      sclr = 1'b1; sinc = 1'b0;
      @(negedge clk);

      // reset state
      cyc(1, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      chk("reset.count", a_count, 0);
      chk("reset.wrap",  a_wrap,  0);

      // vector table
      foreach (vecs[i]) begin
         cyc(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l, vecs[i].lv);
         chk($sformatf("vec%0d.tc", i),    a_tc,    vecs[i].x_tc);
         chk($sformatf("vec%0d.count", i), a_count, vecs[i].x_count);
         chk($sformatf("vec%0d.wrap", i),  a_wrap,  vecs[i].x_wrap);
      end

      // full up sweep with wrap
      cyc(1, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      for (int i = 0; i < 105; i++) begin
         cyc(0, 1, 1, 0, 0);
         chk("up.tc",    a_tc,    (i % 100 == 99) ? 1 : 0);
         chk("up.count", a_count, (i + 1) % 100);
         chk("up.wrap",  a_wrap,  (i == 99) ? 1 : 0);
      end

      // down from reset
      cyc(1, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("dn0.tc", a_tc, 1);
      chk("dn0.count", a_count, 99);
      chk("dn0.wrap", a_wrap, 1);
      cyc(0, 1, 0, 0, 0);
      chk("dn1.count", a_count, 98);
      chk("dn1.wrap", a_wrap, 0);
      cyc(0, 1, 0, 0, 0);
      chk("dn2.count", a_count, 97);

      // reset mid-count overrides load and enable
      cyc(0, 0, 1, 1, 57);
      chk("mid.load", a_count, 57);
      cyc(1, 1, 1, 1, 10);
      chk("mid.rst.count", a_count, 0);
      chk("mid.rst.wrap", a_wrap, 0);

      // hold with en=0
      cyc(0, 0, 1, 1, 64);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, i[0], 0, 0);
         chk("hold.tc", a_tc, 0);
         chk("hold.count", a_count, 64);
         chk("hold.wrap", a_wrap, 0);
      end

      // randomized against reference model
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0), int'($urandom_range(0, 127)));
         chk_model("rand");
      end

      // modulus-7 instance: 21 up-counts
      cyc7(1, 0);
      chk("m7.reset", int'(count7), 0);
      wraps7 = 0;
      exp7 = 0;
      for (int i = 0; i < 21; i++) begin
         rst7 = 1'b0; en7 = 1'b1; up7 = 1'b1; load7 = 1'b0;
         #1;
         chk("m7.tc", int'(tc7), (exp7 == M7 - 1) ? 1 : 0);
         @(posedge clk);
         #1;
         if (exp7 == M7 - 1) wraps7++;
         chk("m7.wrap", int'(wrap7), (exp7 == M7 - 1) ? 1 : 0);
         exp7 = (exp7 + 1) % M7;
         chk("m7.count", int'(count7), exp7);
         @(negedge clk);
      end
      chk("m7.wraps", wraps7, 3);
`ifdef MODN_WRAP_CNT_EN
      chk("m7.wrap_cnt", int'(wrap_cnt7), 3);
      cyc7(1, 1);
      chk("m7.wrap_cnt.rst", int'(wrap_cnt7), 0);
`endif
      cyc7(1, 1);
      chk("m7.rst.count", int'(count7), 0);

      // saturating counter standalone
      @(negedge clk);
      sclr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sinc = 1'b1;
         @(posedge clk);
         #1;
         chk("sat.cnt", int'(scnt), (i + 1 > 7) ? 7 : i + 1);
         @(negedge clk);
      end
      sinc = 1'b0;
      sclr = 1'b1;
      @(posedge clk);
      #1;
      chk("sat.clr", int'(scnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
